pack_buffer_dual: RTL and testbench

- Parametrised successor to the fixed 32-in/64-out dual-port weight buffer.
- Accepts narrow beats on a valid/ready stream and packs RATIO consecutive beats into one wide word.
- Stores wide words in an internal DEPTH-entry circular buffer and presents them on a wide valid/ready stream toward the NDP unit.
- Adds full/empty flow control, partial-word flush with lane mask, and selectable lane order.

---
 rtl/pack_buffer_dual.sv | 166 ++++++++++++++++
 tb/tb_pack_buffer_dual.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pack_buffer_dual.sv
// Narrow-to-wide stream packer: RATIO narrow beats (or fewer, closed by in_last) form one
// wide word with a lane keep mask, queued in a DEPTH-entry circular buffer with registered read.
module pack_buffer_dual #(
   parameter int IN_WIDTH  = 32,
   parameter int RATIO     = 2,
   parameter int OUT_WIDTH = IN_WIDTH * RATIO,
   parameter int DEPTH     = 16,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [IN_WIDTH-1:0]      in_data,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_WIDTH-1:0]     out_data,
   output logic [RATIO-1:0]         out_keep,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int LW = $clog2(RATIO);
   localparam int PW = $clog2(DEPTH) + 1;
   localparam int AW = PW - 1;
   localparam int SW = OUT_WIDTH + RATIO;

   logic [LW-1:0]        lane_q, lane_d;
   logic [OUT_WIDTH-1:0] pack_q, pack_d;
   logic [RATIO-1:0]     pack_keep_q, pack_keep_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]        count_q, count_d;
   logic                 in_ready_q, in_ready_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic [RATIO-1:0]     out_keep_q, out_keep_d;

   logic [SW-1:0]        mem_q [DEPTH];
   logic [SW-1:0]        mem_rd_q;

   logic [LW-1:0]        lane_sel;
   logic [OUT_WIDTH-1:0] merged_word;
   logic [RATIO-1:0]     merged_keep;
   logic                 accept;
   logic                 commit;
   logic                 pop;
   logic                 out_load;
   logic                 rd_free;
   logic                 rd_en;

   always_comb begin
      lane_sel = lane_q;
      if (MSB_FIRST) begin
         lane_sel = LW'(RATIO - 1) - lane_q;
      end
   end

   // Pack register with the incoming beat merged into its lane; this is what a commit stores.
   for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      assign merged_word[gi*IN_WIDTH +: IN_WIDTH] =
         (lane_sel == LW'(gi)) ? in_data : pack_q[gi*IN_WIDTH +: IN_WIDTH];
      assign merged_keep[gi] = (lane_sel == LW'(gi)) | pack_keep_q[gi];
   end

   assign accept = in_valid & in_ready_q;
   assign commit = accept & (in_last | (lane_q == LW'(RATIO - 1)));
   assign pop    = out_valid_q & out_ready;

   // Two staging registers (RAM read register, output register) keep the stream gap-free.
   assign out_load = rd_valid_q & (~out_valid_q | pop);
   assign rd_free  = ~rd_valid_q | out_load;
   assign rd_en    = (wr_ptr_q != rd_ptr_q) & rd_free;

   always_comb begin
      lane_d      = lane_q;
      pack_d      = pack_q;
      pack_keep_d = pack_keep_q;
      if (commit) begin
         lane_d      = '0;
         pack_d      = '0;
         pack_keep_d = '0;
      end else if (accept) begin
         lane_d      = lane_q + LW'(1);
         pack_d      = merged_word;
         pack_keep_d = merged_keep;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(commit);
      rd_ptr_d = rd_ptr_q + PW'(rd_en);
      count_d  = count_q;
      unique case ({commit, pop})
         2'b10:   count_d = count_q + PW'(1);
         2'b01:   count_d = count_q - PW'(1);
         default: count_d = count_q;
      endcase
      in_ready_d = (count_d < PW'(DEPTH));
   end

   always_comb begin
      rd_valid_d  = rd_valid_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      if (rd_en) begin
         rd_valid_d = 1'b1;
      end else if (out_load) begin
         rd_valid_d = 1'b0;
      end
      if (out_load) begin
         out_valid_d = 1'b1;
         out_data_d  = mem_rd_q[OUT_WIDTH-1:0];
         out_keep_d  = mem_rd_q[SW-1:OUT_WIDTH];
      end else if (pop) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lane_q      <= '0;
         pack_q      <= '0;
         pack_keep_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
      end else begin
         lane_q      <= lane_d;
         pack_q      <= pack_d;
         pack_keep_q <= pack_keep_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         rd_valid_q  <= rd_valid_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
      end
   end

   // Storage array carries no reset so it maps onto block RAM; pointers alone define content.
   always_ff @(posedge clk) begin
      if (commit) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {merged_keep, merged_word};
      end
      if (rd_en) begin
         mem_rd_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_keep  = out_keep_q;
   assign count     = count_q;

endmodule

// File: tb/tb_pack_buffer_dual.sv
// Scoreboard bench for pack_buffer_dual: one LSB-first and one MSB-first instance share stimulus;
// expected words are built by a lane model at beat acceptance and compared when each word pops.
`timescale 1ns/1ps
module tb_pack_buffer_dual;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready0, in_ready1;
   logic        out_valid0, out_valid1;
   logic [63:0] out_data0, out_data1;
   logic [1:0]  out_keep0, out_keep1;
   logic [4:0]  count0, count1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [65:0] exp0[$];
   logic [65:0] exp1[$];
   logic [65:0] log0[$];
   logic [65:0] log1[$];
   logic [65:0] e0, e1;

   int          lane_m = 0;
   logic [63:0] acc0 = '0, acc1 = '0;
   logic [1:0]  keep0 = '0, keep1 = '0;
   int          commit_cyc = 0;
   int          first_valid_cyc = -1;
   int          max_cnt = 0;
   bit          mon_en = 1'b0;
   bit          prev_hold = 1'b0;
   logic [65:0] prev_word = '0;
   bit          rnd_done = 1'b0;

   pack_buffer_dual #(.IN_WIDTH(32), .RATIO(2), .DEPTH(16), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(rst_n),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_keep(out_keep0),
      .count(count0)
   );

   pack_buffer_dual #(.IN_WIDTH(32), .RATIO(2), .DEPTH(16), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset(rst_n),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_keep(out_keep1),
      .count(count1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output-side scoreboard: count tracking, stability under stall, and in-order word compare.
   always @(negedge clk) begin
      if (!mon_en) begin
         prev_hold = 1'b0;
      end else begin
         if (int'(count0) > max_cnt) max_cnt = int'(count0);
         checks++;
         if (int'(count0) !== exp0.size() || int'(count1) !== exp1.size()) begin
            errors++;
            $display("FAIL count_track: got lsb=%0d msb=%0d, expected %0d", count0, count1, exp0.size());
         end
         checks++;
         if (out_valid1 !== out_valid0) begin
            errors++;
            $display("FAIL valid_match: got lsb=%0b msb=%0b, expected equal", out_valid0, out_valid1);
         end
         if (prev_hold) begin
            checks++;
            if ({out_keep0, out_data0} !== prev_word) begin
               errors++;
               $display("FAIL hold_stable: got %h, expected %h", {out_keep0, out_data0}, prev_word);
            end
         end
         prev_hold = out_valid0 && !out_ready;
         prev_word = {out_keep0, out_data0};
         if (out_valid0 && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (out_valid0 && out_ready) begin
            checks++;
            if (exp0.size() == 0 || exp1.size() == 0) begin
               errors++;
               $display("FAIL pop_underflow: got word %h, expected no output", {out_keep0, out_data0});
            end else begin
               e0 = exp0.pop_front();
               e1 = exp1.pop_front();
               if ({out_keep0, out_data0} !== e0) begin
                  errors++;
                  $display("FAIL pop_lsb: got %h, expected %h", {out_keep0, out_data0}, e0);
               end
               checks++;
               if ({out_keep1, out_data1} !== e1) begin
                  errors++;
                  $display("FAIL pop_msb: got %h, expected %h", {out_keep1, out_data1}, e1);
               end
               $display("pop  lsb=%h msb=%h", {out_keep0, out_data0}, {out_keep1, out_data1});
            end
            log0.push_back({out_keep0, out_data0});
            log1.push_back({out_keep1, out_data1});
         end
      end
   end

   task automatic model_clear();
      lane_m = 0;
      acc0 = '0; acc1 = '0;
      keep0 = '0; keep1 = '0;
   endtask

   task automatic model_accept(input logic [31:0] d, input logic last);
      acc0[lane_m*32 +: 32] = d;
      keep0[lane_m] = 1'b1;
      acc1[(1-lane_m)*32 +: 32] = d;
      keep1[1-lane_m] = 1'b1;
      if (lane_m == 1 || last) begin
         exp0.push_back({keep0, acc0});
         exp1.push_back({keep1, acc1});
         commit_cyc = cyc;
         model_clear();
      end else begin
         lane_m = 1;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send_beat(input logic [31:0] d, input logic last);
      int  waitc = 0;
      bit  ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!ok && waitc < 300) begin
         @(negedge clk);
         if (in_ready0) begin
            @(posedge clk);
            #1;
            model_accept(d, last);
            ok = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            waitc++;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL beat_accept: got no accept in 300 cycles, expected accept of %h", d);
      end else begin
         $display("beat data=%h last=%0b", d, last);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      out_ready = 1'b1;
      while ((exp0.size() != 0 || out_valid0) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (exp0.size() != 0 || out_valid0) begin
         errors++;
         $display("FAIL drain: got %0d words pending, expected 0", exp0.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({in_ready0, out_valid0, out_keep0, count0} !== 9'd0 || out_data0 !== 64'd0) begin
         errors++;
         $display("FAIL reset_state: got rdy=%0b vld=%0b keep=%b cnt=%0d data=%h, expected all zero",
                  in_ready0, out_valid0, out_keep0, count0, out_data0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got in_ready=%0b/%0b, expected 1", in_ready0, in_ready1);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_basic_pack();
      log0.delete(); log1.delete();
      first_valid_cyc = -1;
      out_ready = 1'b1;
      send_beat(32'h11111111, 1'b0);
      send_beat(32'h22222222, 1'b0);
      wait_drain();
      checks++;
      if (log0.size() != 1 || log0[0] !== {2'b11, 64'h22222222_11111111}) begin
         errors++;
         $display("FAIL basic_lsb: got %0d words, first %h, expected 3_2222222211111111", log0.size(), log0[0]);
      end
      checks++;
      if (log1.size() != 1 || log1[0] !== {2'b11, 64'h11111111_22222222}) begin
         errors++;
         $display("FAIL basic_msb: got %h, expected 3_1111111122222222", log1[0]);
      end
      checks++;
      if (first_valid_cyc - commit_cyc < 2) begin
         errors++;
         $display("FAIL latency: got %0d cycles, expected >= 2", first_valid_cyc - commit_cyc);
      end
      checks++;
      if (count0 !== 5'd0) begin
         errors++;
         $display("FAIL basic_count: got %0d, expected 0", count0);
      end
   endtask

   task automatic test_partial_flush();
      log0.delete(); log1.delete();
      out_ready = 1'b1;
      send_beat(32'hDEADBEEF, 1'b1);
      send_beat(32'h33333333, 1'b0);
      send_beat(32'h44444444, 1'b0);
      wait_drain();
      checks++;
      if (log0.size() != 2 || log0[0] !== {2'b01, 64'h00000000_DEADBEEF}) begin
         errors++;
         $display("FAIL flush_lsb: got %h, expected 1_00000000DEADBEEF", log0[0]);
      end
      checks++;
      if (log1.size() != 2 || log1[0] !== {2'b10, 64'hDEADBEEF_00000000}) begin
         errors++;
         $display("FAIL flush_msb: got %h, expected 2_DEADBEEF00000000", log1[0]);
      end
      checks++;
      if (log0.size() != 2 || log0[1] !== {2'b11, 64'h44444444_33333333}) begin
         errors++;
         $display("FAIL flush_next: got %h, expected 3_4444444433333333", log0[1]);
      end
   endtask

   task automatic test_fill_backpressure();
      logic [65:0] want;
      log0.delete(); log1.delete();
      out_ready = 1'b0;
      for (int i = 1; i <= 32; i++) send_beat(32'(i), 1'b0);
      @(negedge clk);
      checks++;
      if (count0 !== 5'd16 || in_ready0 !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: got count=%0d in_ready=%0b, expected 16/0", count0, in_ready0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 32'd33;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (in_ready0 !== 1'b0 || count0 !== 5'd16) begin
            errors++;
            $display("FAIL beat33_block: got in_ready=%0b count=%0d, expected 0/16", in_ready0, count0);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      wait_drain();
      checks++;
      if (log0.size() != 16) begin
         errors++;
         $display("FAIL drain_count: got %0d words, expected 16", log0.size());
      end
      for (int k = 0; k < 16 && k < log0.size(); k++) begin
         want = {2'b11, 32'(2*k+2), 32'(2*k+1)};
         checks++;
         if (log0[k] !== want) begin
            errors++;
            $display("FAIL drain_order[%0d]: got %h, expected %h", k, log0[k], want);
         end
      end
   endtask

   task automatic test_random_wrap();
      max_cnt = 0;
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               send_beat($urandom, (i == 99) ? 1'b1 : ($urandom_range(0, 7) == 0));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      wait_drain();
      checks++;
      if (max_cnt > 16) begin
         errors++;
         $display("FAIL count_bound: got max %0d, expected <= 16", max_cnt);
      end
   endtask

   task automatic test_reset_midop();
      log0.delete(); log1.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 11; i++) send_beat(32'h100 + 32'(i), 1'b0);
      #2;
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid0 !== 1'b0 || count0 !== 5'd0 || in_ready0 !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear: got vld=%0b cnt=%0d rdy=%0b, expected 0/0/0",
                  out_valid0, count0, in_ready0);
      end
      exp0.delete(); exp1.delete();
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready0 !== 1'b1 || count0 !== 5'd0 || out_valid0 !== 1'b0) begin
         errors++;
         $display("FAIL midreset_release: got rdy=%0b cnt=%0d vld=%0b, expected 1/0/0",
                  in_ready0, count0, out_valid0);
      end
      mon_en = 1'b1;
      out_ready = 1'b1;
      send_beat(32'hA5A5A5A5, 1'b0);
      send_beat(32'h5A5A5A5A, 1'b0);
      wait_drain();
      checks++;
      if (log0.size() != 1 || log0[0] !== {2'b11, 64'h5A5A5A5A_A5A5A5A5}) begin
         errors++;
         $display("FAIL midreset_first: got %0d words, first %h, expected 3_5A5A5A5AA5A5A5A5",
                  log0.size(), log0[0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic_pack();
      test_partial_flush();
      test_fill_backpressure();
      test_random_wrap();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
